// File: rtl/arbiter_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM state
// type, default grant limit and the rotating-priority pick helper.
package arbiter_pkg;

  localparam int unsigned N_REQ                  = 8;
  localparam int unsigned IDX_W                  = 3;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set request bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
  // Returns ptr when no bit is set; callers qualify with |req.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec3
  import arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_onehot
);

  // Decode the index into a single set bit, gated by the enable.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_8.sv
// 8-requester round-robin arbiter with a two-state IDLE/GRANT FSM.
// A grant is issued one cycle after a qualifying request and held until
// the owner signals done or drops its request; the pointer then moves to
// the requester after the owner. Every release is followed by at least one
// idle cycle.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to
// TIMEOUT_CYCLES cycles, with a one-cycle timeout pulse on forced release.
module arbiter_8
  import arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;

  logic             w_any_req;
  logic [IDX_W-1:0] w_pick;
  logic             w_release;
  logic [N_REQ-1:0] w_gnt;

  assign w_any_req = |req;
  assign w_pick    = rr_pick(req, r_ptr);
  // Owner-initiated release: explicit done or the owner's request falling.
  assign w_release = done | ~req[r_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_force;

  // Forced release only when the owner is not already releasing itself,
  // so done on the terminal count stays a normal release.
  assign w_force = (r_cnt == CNT_LAST) & ~w_release;

  // Arbitration FSM with grant-length counter and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && w_any_req) begin
            r_state <= GRANT;
            r_idx   <= w_pick;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release || w_force) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_ptr     <= r_idx + IDX_W'(1);
            r_timeout <= w_force;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign timeout = r_timeout;
`else
  // Parameter kept for a build-independent interface; unused here.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 32'd256);

  // Arbitration FSM; grants are held until the owner releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && w_any_req) begin
            r_state <= GRANT;
            r_idx   <= w_pick;
            r_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ptr   <= r_idx + IDX_W'(1);
          end
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  onehot_dec3 u_dec (
    .i_idx    (r_idx),
    .i_en     (r_valid),
    .o_onehot (w_gnt)
  );

  assign gnt       = w_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;

endmodule

// File: tb/tb_arbiter_8.sv
// Self-checking bench for arbiter_8: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against
// a behavioural owner/pointer model. Honors ARB_TIMEOUT_EN.
module tb_arbiter_8;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the resource, where priority starts,
  // how many cycles the current grant has been visible.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  arbiter_8 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (enable && req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (req[(m_ptr + k) % 8]) begin
              m_owner = (m_ptr + k) % 8;
              break;
            end
          end
          m_held = 1;
        end
      end else if (done || !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_held == TO) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end
`endif
      else begin
        m_held++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    chk("cyc_gnt", {24'd0, gnt}, {24'd0, eg});
    chk("cyc_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
    chk("cyc_timeout", {31'd0, timeout}, {31'd0, m_to});
    if (m_owner >= 0) chk("cyc_idx", {29'd0, gnt_idx}, 32'(m_owner));
    if (rst) chk("cyc_rst_idx", {29'd0, gnt_idx}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step();
    chk("reset_gnt", {24'd0, gnt}, 32'h00);
    chk("reset_valid", {31'd0, gnt_valid}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;

    // First grant, release by done, pointer moves to 1.
    enable = 1'b1; req = 8'h01; done = 1'b0;
    step();
    chk("first_gnt", {24'd0, gnt}, 32'h01);
    chk("first_idx", {29'd0, gnt_idx}, 32'd0);
    chk("first_valid", {31'd0, gnt_valid}, 32'd1);
    done = 1'b1;
    step();
    chk("done_gnt", {24'd0, gnt}, 32'h00);
    done = 1'b0; req = 8'h03;
    step();
    chk("ptr1_gnt", {24'd0, gnt}, 32'h02);
    chk("ptr1_idx", {29'd0, gnt_idx}, 32'd1);

    // Full round robin with req held at FF.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      done = 1'b0;
      step();
      chk("rr_gnt", {24'd0, gnt}, 32'(1 << (k % 8)));
      done = 1'b1;
      step();
      chk("rr_gap", {24'd0, gnt}, 32'h00);
    end
    done = 1'b0;

    // Owner 7 releases with 0 pending: pointer wraps.
    do_reset();
    req = 8'h80;
    step();
    chk("wrap_own7", {24'd0, gnt}, 32'h80);
    req = 8'h81; done = 1'b1;
    step();
    chk("wrap_gap", {24'd0, gnt}, 32'h00);
    done = 1'b0;
    step();
    chk("wrap_gnt", {24'd0, gnt}, 32'h01);

    // Enable gating: no new grant when low, existing grant held.
    do_reset();
    enable = 1'b0; req = 8'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en0_gnt", {24'd0, gnt}, 32'h00);
    end
    enable = 1'b1;
    step();
    chk("en1_gnt", {24'd0, gnt}, 32'h10);
    enable = 1'b0; req = 8'h1F;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_hold_gnt", {24'd0, gnt}, 32'h10);
    end
    done = 1'b1;
    step();
    chk("en_rel_gnt", {24'd0, gnt}, 32'h00);
    done = 1'b0;
    step();
    chk("en0_after", {24'd0, gnt}, 32'h00);
    enable = 1'b1;

    // Asynchronous reset mid-grant, then arbitration restarts at ptr 0.
    do_reset();
    req = 8'h20;
    step();
    chk("arst_pre", {24'd0, gnt}, 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {24'd0, gnt}, 32'h00);
    chk("arst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("arst_idx", {29'd0, gnt_idx}, 32'd0);
    step();
    rst = 1'b0; req = 8'h24;
    step();
    chk("arst_next", {24'd0, gnt}, 32'h04);

`ifdef ARB_TIMEOUT_EN
    // Forced release after exactly TO cycles, then pointer at 3.
    do_reset();
    req = 8'h04;
    step();
    n = 0;
    while (gnt == 8'h04 && n < 40) begin
      n++;
      step();
    end
    chk("to_len", 32'(n), 32'(TO));
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    req = 8'h0C;
    step();
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    chk("to_ptr3", {24'd0, gnt}, 32'h08);

    // done on the terminal count is a normal release.
    do_reset();
    req = 8'h04;
    step();
    for (int k = 0; k < TO - 1; k++) step();
    done = 1'b1;
    step();
    chk("term_done_to", {31'd0, timeout}, 32'd0);
    chk("term_done_gnt", {24'd0, gnt}, 32'h00);
    done = 1'b0;
`else
    // Without the timeout feature a grant is held indefinitely.
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 40; k++) step();
    chk("hold_gnt", {24'd0, gnt}, 32'h04);
    chk("hold_timeout", {31'd0, timeout}, 32'd0);
`endif

    // Randomized traffic; the negedge compare checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      enable = ($urandom_range(0, 4) != 0);
`ifdef ARB_TIMEOUT_EN
      done = ($urandom_range(0, 39) == 0);
`else
      done = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #3;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_8.md
ARBITER_8 -- requirements
Module: arbiter_8

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum grant length in cycles, legal range 2..256.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 SHALL have port req  input  8  per-requester request, bit n = requester n.
REQ-006 SHALL have port done  input  1  the current owner releases the resource.
REQ-007 SHALL have port gnt  output  8  one-hot grant, all-zero when no owner.
REQ-008 SHALL have port gnt_idx  output  3  binary index of the owner, valid only while gnt_valid=1.
REQ-009 SHALL have port gnt_valid  output  1  high while a grant is held.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement two states: IDLE (no owner) and GRANT (owner held).
REQ-012 SHALL hold a 3-bit round-robin pointer ptr; priority order is ptr, ptr+1, ... ptr+7 (mod 8).
REQ-013 SHALL, in IDLE with enable=1 and req!=0 at an edge, select the first set req bit in priority order and enter GRANT at that edge, so gnt/gnt_idx/gnt_valid are high in the next cycle (1-cycle latency).
REQ-014 SHALL remain in IDLE with all grant outputs 0 when enable=0 or req=0.
REQ-015 SHALL drive gnt as the one-hot decode of gnt_idx gated by gnt_valid; never more than one bit set.
REQ-016 SHALL, in GRANT, hold the owner unchanged regardless of enable or other req bits.
REQ-017 SHALL release on the edge where done=1 or req[gnt_idx]=0; on release: state to IDLE, gnt_valid to 0, ptr to gnt_idx+1 with 7 wrapping to 0.
REQ-018 SHALL keep grant outputs low for at least one cycle after every release (no back-to-back grants).
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL treat done and req[gnt_idx] falling together as one normal release with timeout=0.
REQ-021 SHALL not change ptr while in IDLE or while a grant is held.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0 and clear the timeout counter, independent of clk.
REQ-023 SHALL, on reset during GRANT, drop the grant immediately and not advance ptr.
REQ-024 SHALL evaluate its first arbitration at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with ARB_TIMEOUT_EN defined, count cycles spent in GRANT, starting at 0 on the grant edge.
REQ-026 SHALL, with ARB_TIMEOUT_EN defined, force a release when the count reaches TIMEOUT_CYCLES-1 and done=0 and req[gnt_idx]=1 (the grant lasts TIMEOUT_CYCLES cycles); ptr advances as in REQ-017 and timeout pulses high for the following cycle.
REQ-027 SHALL, with ARB_TIMEOUT_EN defined, treat done=1 on the terminal count as a normal release with timeout=0.
REQ-028 SHALL, without ARB_TIMEOUT_EN, omit the counter, tie timeout to 0, and hold grants indefinitely; the port list is identical in both builds.

Structure
REQ-029 SHALL place in package arbiter_pkg: N_REQ=8, IDX_W=3, the IDLE/GRANT state enumeration and the default TIMEOUT_CYCLES.
REQ-030 SHALL use one sub-module, onehot_dec3 (3-to-8 decoder with enable), to produce gnt from gnt_idx and gnt_valid.

Verification
REQ-031 SHALL cover: reset, then req=8'b0000_0001 with enable=1 -> gnt=8'h01 and gnt_idx=0 one cycle later; done pulse -> gnt=0 next cycle and ptr=1.
REQ-032 SHALL cover: req=8'hFF held, done each grant -> grant order 0,1,...,7,0, with one idle cycle between grants.
REQ-033 SHALL cover: owner 7 releases with req=8'h81 pending -> ptr wraps to 0 and the next gnt=8'h01.
REQ-034 SHALL cover: enable=0 with req=8'h10 -> gnt stays 0; enable dropped mid-grant -> grant held until done.
REQ-035 SHALL cover, with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req=8'h04 held and done=0 -> gnt=8'h04 for exactly 16 cycles, then a 1-cycle timeout pulse and ptr=3.
REQ-036 SHALL cover: rst asserted mid-grant -> all outputs 0 asynchronously, and the next arbitration after reset starts from ptr=0.
